// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing defaults and derived line/frame boundaries.
// Shared by the sync generator; all coordinates are unsigned COORD_W-bit.
package vga_timing_pkg;
  localparam int COORD_W = 10;

  localparam int TICK_DIV_DEF    = 4;
  localparam int H_DISPLAY_DEF   = 640;
  localparam int H_FRONT_DEF     = 16;
  localparam int H_SYNC_DEF      = 96;
  localparam int H_BACK_DEF      = 48;
  localparam int V_DISPLAY_DEF   = 480;
  localparam int V_FRONT_DEF     = 10;
  localparam int V_SYNC_DEF      = 2;
  localparam int V_BACK_DEF      = 33;
  localparam int SYNC_ACTIVE_DEF = 0;

  localparam int H_TOTAL      = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL      = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
  localparam int H_SYNC_START = H_DISPLAY_DEF + H_FRONT_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
  localparam int V_SYNC_START = V_DISPLAY_DEF + V_FRONT_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [11:0]        rgb_t;
endpackage

// File: rtl/vga_tick_gen.sv
// Pixel-rate divider: o_tick is high on the last system clock of each pixel period.
// Combinational from the count, so it is low in reset and first rises TICK_DIV-1 clks after release.
module vga_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);
  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == CNT_LAST);
endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel counters, sync decode and a one-pixel registered colour/sync stage.
// pixel_x/pixel_y and video_on are current; rgb/hsync/vsync lag them by one pixel period.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int TICK_DIV    = TICK_DIV_DEF,
  parameter int H_DISPLAY   = H_DISPLAY_DEF,
  parameter int H_FRONT     = H_FRONT_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_BACK      = H_BACK_DEF,
  parameter int V_DISPLAY   = V_DISPLAY_DEF,
  parameter int V_FRONT     = V_FRONT_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_BACK      = V_BACK_DEF,
  parameter int SYNC_ACTIVE = SYNC_ACTIVE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [11:0]        rgb_in,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               video_on,
  output logic               pixel_tick,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic [11:0]        rgb
);
  localparam int HT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(HT - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(VT - 1);
  localparam logic [COORD_W-1:0] X_VIS  = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] Y_VIS  = COORD_W'(V_DISPLAY);
  localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_DISPLAY + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_DISPLAY + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic               S_ACT  = (SYNC_ACTIVE != 0);

  logic               w_tick;
  logic               w_hs;
  logic               w_vs;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               r_fs;
  logic               r_hs;
  logic               r_vs;
  logic [11:0]        r_rgb;

  vga_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .i_clk  (clk),
    .i_rst  (reset),
    .o_tick (w_tick)
  );

  assign w_hs = ((r_x >= HS_BEG) && (r_x <= HS_END)) ? S_ACT : ~S_ACT;
  assign w_vs = ((r_y >= VS_BEG) && (r_y <= VS_END)) ? S_ACT : ~S_ACT;

  // Output stage samples on the same tick that advances the counters, hence the one-pixel lag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x   <= '0;
      r_y   <= '0;
      r_fs  <= 1'b0;
      r_hs  <= ~S_ACT;
      r_vs  <= ~S_ACT;
      r_rgb <= 12'h000;
    end else begin
      r_fs <= 1'b0;
      if (w_tick) begin
        r_rgb <= video_on ? rgb_in : 12'h000;
        r_hs  <= w_hs;
        r_vs  <= w_vs;
        if (r_x == X_LAST) begin
          r_x <= '0;
          if (r_y == Y_LAST) begin
            r_y  <= '0;
            r_fs <= 1'b1;
          end else begin
            r_y <= r_y + 1'b1;
          end
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  assign pixel_x     = r_x;
  assign pixel_y     = r_y;
  assign video_on    = (r_x < X_VIS) && (r_y < Y_VIS);
  assign pixel_tick  = w_tick;
  assign frame_start = r_fs;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign rgb         = r_rgb;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench: full-size 640x480 instance for line timing, a shrunken instance for whole-frame behaviour.
// Both are checked every cycle against a time-indexed model of the pixel schedule.
module tb_vga_sync_gen;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] rgb_in = 12'hF0A;

  logic [9:0]  f_x, f_y, s_x, s_y;
  logic        f_von, f_tick, f_fs, f_hs, f_vs;
  logic        s_von, s_tick, s_fs, s_hs, s_vs;
  logic [11:0] f_rgb, s_rgb;

  int tests = 0;
  int fails = 0;
  int mode = 0;
  bit gen_ok = 1'b0;
  logic [11:0] g1 = '0, g2 = '0, g3 = '0;

  always #5 clk = ~clk;

  vga_sync_gen u_full (
    .clk(clk), .reset(reset), .rgb_in(rgb_in),
    .pixel_x(f_x), .pixel_y(f_y), .video_on(f_von), .pixel_tick(f_tick),
    .frame_start(f_fs), .hsync(f_hs), .vsync(f_vs), .rgb(f_rgb)
  );

  vga_sync_gen #(
    .TICK_DIV(4), .H_DISPLAY(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
    .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_ACTIVE(1)
  ) u_small (
    .clk(clk), .reset(reset), .rgb_in(rgb_in),
    .pixel_x(s_x), .pixel_y(s_y), .video_on(s_von), .pixel_tick(s_tick),
    .frame_start(s_fs), .hsync(s_hs), .vsync(s_vs), .rgb(s_rgb)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: t clock edges since reset release fully determine every output.
  task automatic check_dut(input string tag, input bit rst, input int t,
                           input int D, input int HD, input int HF, input int HS, input int HB,
                           input int VD, input int VF, input int VS, input int VB, input int ACT,
                           input logic [11:0] lin, input bit gen_chk,
                           input logic [9:0] x, input logic [9:0] y,
                           input logic von, input logic tick, input logic fs,
                           input logic hs, input logic vs, input logic [11:0] rgb);
    int HT, VT, p, ph, ex, ey, qx, qy;
    logic e_tick, e_fs, e_von, e_hs, e_vs;
    logic [11:0] e_rgb;
    HT = HD + HF + HS + HB;
    VT = VD + VF + VS + VB;
    if (rst) begin
      ex = 0; ey = 0; e_tick = 0; e_fs = 0; e_von = 1;
      e_hs = (ACT == 0); e_vs = (ACT == 0); e_rgb = 12'h000;
    end else begin
      p  = t / D;
      ph = t % D;
      ex = p % HT;
      ey = (p / HT) % VT;
      e_tick = (ph == D - 1);
      e_fs   = (ph == 0) && (p > 0) && (p % (HT * VT) == 0);
      e_von  = (ex < HD) && (ey < VD);
      if (p == 0) begin
        e_hs = (ACT == 0); e_vs = (ACT == 0); e_rgb = 12'h000;
      end else begin
        qx = (p - 1) % HT;
        qy = ((p - 1) / HT) % VT;
        e_hs  = (qx >= HD + HF && qx < HD + HF + HS) ? (ACT != 0) : (ACT == 0);
        e_vs  = (qy >= VD + VF && qy < VD + VF + VS) ? (ACT != 0) : (ACT == 0);
        e_rgb = (qx < HD && qy < VD) ? lin : 12'h000;
        if (gen_chk && qx < HD && qy < VD)
          chk({tag, ".gen_rgb"}, rgb, {20'd0, qx[3:0], qy[3:0], 4'h5});
      end
    end
    chk({tag, ".x"}, x, ex);
    chk({tag, ".y"}, y, ey);
    chk({tag, ".tick"}, tick, e_tick);
    chk({tag, ".fs"}, fs, e_fs);
    chk({tag, ".von"}, von, e_von);
    chk({tag, ".hs"}, hs, e_hs);
    chk({tag, ".vs"}, vs, e_vs);
    chk({tag, ".rgb"}, rgb, e_rgb);
  endtask

  task automatic rst_literal(input string tag);
    chk({tag, ".f_x"}, f_x, 0);       chk({tag, ".f_y"}, f_y, 0);
    chk({tag, ".f_tick"}, f_tick, 0); chk({tag, ".f_fs"}, f_fs, 0);
    chk({tag, ".f_von"}, f_von, 1);   chk({tag, ".f_hs"}, f_hs, 1);
    chk({tag, ".f_vs"}, f_vs, 1);     chk({tag, ".f_rgb"}, f_rgb, 12'h000);
    chk({tag, ".s_x"}, s_x, 0);       chk({tag, ".s_y"}, s_y, 0);
    chk({tag, ".s_hs"}, s_hs, 0);     chk({tag, ".s_vs"}, s_vs, 0);
    chk({tag, ".s_rgb"}, s_rgb, 12'h000);
  endtask

  // Image generator: 3-clk pipeline from the small instance's coordinates, or fixed/random colour.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mode == 1) rgb_in = g3;
      else if (mode == 2 && $urandom_range(0, 3) == 0) rgb_in = 12'($urandom);
      else if (mode == 0) rgb_in = 12'hF0A;
      g3 = g2;
      g2 = g1;
      g1 = {s_x[3:0], s_y[3:0], 4'h5};
    end
  end

  initial begin
    int t;
    logic [11:0] lin;
    t = 0;
    lin = '0;
    forever begin
      @(negedge clk);
      if (reset) t = 0; else t++;
      check_dut("full", reset, t, 4, 640, 16, 96, 48, 480, 10, 2, 33, 0, lin, 1'b0,
                f_x, f_y, f_von, f_tick, f_fs, f_hs, f_vs, f_rgb);
      if (!reset && (t % 4) == 3) lin = rgb_in;
    end
  end

  initial begin
    int t;
    logic [11:0] lin;
    t = 0;
    lin = '0;
    forever begin
      @(negedge clk);
      if (reset) t = 0; else t++;
      check_dut("small", reset, t, 4, 20, 4, 6, 5, 12, 2, 2, 3, 1, lin, gen_ok,
                s_x, s_y, s_von, s_tick, s_fs, s_hs, s_vs, s_rgb);
      if (!reset && (t % 4) == 3) lin = rgb_in;
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst_literal("por");
    #1 reset = 1'b0;

    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (k < 4) begin
        chk("rel.x_hold", f_x, 0);
        chk("rel.tick", f_tick, (k == 3));
        chk("rel.hs_idle", f_hs, 1);
        chk("rel.rgb_idle", f_rgb, 12'h000);
      end else begin
        chk("rel.x_step", f_x, 1);
        chk("rel.rgb_first", f_rgb, 12'hF0A);
      end
    end

    n = 0;
    while (f_x != 10'd656 && n < 4000) begin @(posedge clk); #1; n++; end
    chk("wait_x656", f_x, 656);
    n = 0;
    while (f_hs !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
    chk("hs_fall_delay", n, 4);
    n = 0;
    while (f_hs === 1'b0 && n < 1000) begin @(posedge clk); #1; n++; end
    chk("hs_low_clks", n, 384);
    n = 0;
    while (f_x != 10'd799 && n < 1000) begin @(posedge clk); #1; n++; end
    chk("wait_x799", f_x, 799);
    chk("line0_y", f_y, 0);
    n = 0;
    while (f_x == 10'd799 && n < 10) begin @(posedge clk); #1; n++; end
    chk("wrap_clks", n, 4);
    chk("wrap_x", f_x, 0);
    chk("wrap_y", f_y, 1);

    n = 0;
    while (s_fs !== 1'b1 && n < 3000) begin @(posedge clk); #1; n++; end
    chk("fs_seen", s_fs, 1);
    @(posedge clk); #1;
    chk("fs_width", s_fs, 0);
    n = 1;
    while (s_fs !== 1'b1 && n < 3000) begin @(posedge clk); #1; n++; end
    chk("fs_period", n, 2660);

    n = 0;
    while (s_vs !== 1'b1 && n < 3000) begin @(posedge clk); #1; n++; end
    chk("vs_seen", s_vs, 1);
    n = 0;
    while (s_vs === 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
    chk("vs_high_clks", n, 280);

    mode = 1;
    repeat (8) @(posedge clk);
    gen_ok = 1'b1;
    repeat (5320) @(posedge clk);

    n = 0;
    #1;
    while (!(s_x == 10'd10 && s_y == 10'd7) && n < 3000) begin @(posedge clk); #1; n++; end
    chk("wait_10_7", {s_y, s_x}, {10'd7, 10'd10});
    #1 reset = 1'b1;
    gen_ok = 1'b0;
    #1;
    rst_literal("async");
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    mode = 2;
    repeat (3000) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
